// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - in-order instruction queue that issues to the LSB or RS path
module issue_ctrl #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     rollback,
    input  logic                     valid_from_fet,
    input  logic [31:0]              pc_from_fet,
    input  logic [31:0]              instr_from_fet,
    output logic                     fet_full,
    input  logic                     rob_full,
    input  logic                     rs_full,
    input  logic                     lsb_full,
    output logic                     issue_valid,
    output logic                     issue_is_ls,
    output logic [31:0]              issue_pc,
    output logic [31:0]              issue_instr,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [AW:0]      count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             iv_q, iv_d;
    logic             ils_q, ils_d;
    logic [31:0]      ipc_q, ipc_d;
    logic [31:0]      iin_q, iin_d;

    logic             head_ls;
    logic             push;
    logic             pop;
    logic             mem_we;

    function automatic logic is_ls_op(input logic [31:0] instr);
        return (instr[6:0] == 7'b0000011) || (instr[6:0] == 7'b0100011);
    endfunction

    // Both gating terms come from pre-edge registered state only.
    always_comb begin
        head_ls  = is_ls_op(instr_mem[head_q]);
        fet_full = (count_q == FULL_CNT) || (state_q == ST_FLUSH);
        push     = valid_from_fet && !fet_full;
        pop      = (count_q != '0) && (state_q != ST_FLUSH) && !rob_full &&
                   (head_ls ? !lsb_full : !rs_full);
        mem_we   = rdy && !rollback && push;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;
        stall_d = stall_q;
        iv_d    = 1'b0;
        ils_d   = ils_q;
        ipc_d   = ipc_q;
        iin_d   = iin_q;
        if (rollback) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = ST_FLUSH;
        end else if (rdy) begin
            if (push) begin
                tail_d = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
                iv_d   = 1'b1;
                ils_d  = head_ls;
                ipc_d  = pc_mem[head_q];
                iin_d  = instr_mem[head_q];
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
            case (state_q)
                ST_RUN: begin
                    if ((count_q != '0) && !pop) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (stall_q != '1) begin
                        stall_d = stall_q + CNT_W'(1);
                    end
                    if (pop || (count_q == '0)) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            pc_mem[tail_q]    <= pc_from_fet;
            instr_mem[tail_q] <= instr_from_fet;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= ST_RUN;
            stall_q <= '0;
            iv_q    <= 1'b0;
            ils_q   <= 1'b0;
            ipc_q   <= '0;
            iin_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
            stall_q <= stall_d;
            iv_q    <= iv_d;
            ils_q   <= ils_d;
            ipc_q   <= ipc_d;
            iin_q   <= iin_d;
        end
    end

    assign issue_valid = iv_q;
    assign issue_is_ls = ils_q;
    assign issue_pc    = ipc_q;
    assign issue_instr = iin_q;
    assign stall_cnt   = stall_q;
    assign q_count     = count_q;

endmodule
